// File: rtl/sal_cmd_sched.sv
// DDR2 command scheduler: picks at most one bank request per cycle using fixed class
// priority (REF > PRE > column > ACT) with per-class round-robin and inter-bank timing.

package sal_cmd_sched_pkg;
  typedef logic [13:0] dram_ra_t;
  typedef logic [9:0]  dram_ca_t;
  typedef logic [3:0]  axi_id_t;
  typedef logic [7:0]  axi_len_t;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_e;

  typedef struct packed {
    dram_ra_t ra;
    dram_ca_t ca;
    axi_id_t  id;
    axi_len_t len;
  } bank_payload_t;
endpackage

module sal_cmd_sched
  import sal_cmd_sched_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned T_RRD     = 2,
  parameter int unsigned T_CCD     = 2,
  parameter int unsigned T_WR2RD   = 6,
  parameter int unsigned T_RD2WR   = 4,
  localparam int unsigned BA_W     = $clog2(NUM_BANKS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic     [NUM_BANKS-1:0]        act_req_i,
  input  logic     [NUM_BANKS-1:0]        rd_req_i,
  input  logic     [NUM_BANKS-1:0]        wr_req_i,
  input  logic     [NUM_BANKS-1:0]        pre_req_i,
  input  logic     [NUM_BANKS-1:0]        ref_req_i,
  input  dram_ra_t [NUM_BANKS-1:0]        ra_i,
  input  dram_ca_t [NUM_BANKS-1:0]        ca_i,
  input  axi_id_t  [NUM_BANKS-1:0]        id_i,
  input  axi_len_t [NUM_BANKS-1:0]        len_i,
  output logic     [NUM_BANKS-1:0]        act_gnt_o,
  output logic     [NUM_BANKS-1:0]        rd_gnt_o,
  output logic     [NUM_BANKS-1:0]        wr_gnt_o,
  output logic     [NUM_BANKS-1:0]        pre_gnt_o,
  output logic     [NUM_BANKS-1:0]        ref_gnt_o,
  output logic                            cmd_valid_o,
  output logic     [2:0]                  cmd_o,
  output logic     [BA_W-1:0]             ba_o,
  output dram_ra_t                        ra_o,
  output dram_ca_t                        ca_o,
  output axi_id_t                         id_o,
  output axi_len_t                        len_o
);

  localparam int unsigned T_MAX_A = (T_RRD > T_CCD) ? T_RRD : T_CCD;
  localparam int unsigned T_MAX_B = (T_WR2RD > T_RD2WR) ? T_WR2RD : T_RD2WR;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned CNT_W   = (T_MAX < 2) ? 1 : $clog2(T_MAX + 1);

  // First requesting bank at or after ptr, wrapping; MSB flags a hit.
  function automatic logic [BA_W:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                            input logic [BA_W-1:0]      ptr);
    logic [BA_W:0]   res;
    logic [BA_W-1:0] idx;
    int unsigned     sum;
    res = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      sum = (32'(ptr) + i) % NUM_BANKS;
      idx = BA_W'(sum);
      if (!res[BA_W] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [BA_W-1:0]  r_ptr_act, r_ptr_col, r_ptr_pre, r_ptr_ref;
  logic [CNT_W-1:0] r_rrd_cnt, r_ccd_cnt, r_wr2rd_cnt, r_rd2wr_cnt;
  logic             r_cmd_valid;
  cmd_e             r_cmd;
  logic [BA_W-1:0]  r_ba;
  bank_payload_t    r_pl;

  logic                 w_rrd_ok, w_rd_ok, w_wr_ok;
  logic [NUM_BANKS-1:0] w_act_elig, w_col_elig;
  logic [BA_W:0]        w_pick_act, w_pick_col, w_pick_pre, w_pick_ref;
  cmd_e                 w_cmd;
  logic [BA_W-1:0]      w_bank;
  logic [NUM_BANKS-1:0] w_bank_oh;
  logic                 w_issue;

  assign w_rrd_ok = (r_rrd_cnt == '0);
  assign w_rd_ok  = (r_ccd_cnt == '0) && (r_wr2rd_cnt == '0);
  assign w_wr_ok  = (r_ccd_cnt == '0) && (r_rd2wr_cnt == '0);

  // A bank asking for both RD and WR is a RD bank; it is skipped while RD is illegal.
  assign w_act_elig = act_req_i & {NUM_BANKS{w_rrd_ok}};
  assign w_col_elig = (rd_req_i & {NUM_BANKS{w_rd_ok}})
                    | (~rd_req_i & wr_req_i & {NUM_BANKS{w_wr_ok}});

  assign w_pick_ref = rr_pick(ref_req_i,  r_ptr_ref);
  assign w_pick_pre = rr_pick(pre_req_i,  r_ptr_pre);
  assign w_pick_col = rr_pick(w_col_elig, r_ptr_col);
  assign w_pick_act = rr_pick(w_act_elig, r_ptr_act);

  // Fixed class priority selection.
  always_comb begin
    w_cmd  = CMD_NOP;
    w_bank = '0;
    if (w_pick_ref[BA_W]) begin
      w_cmd  = CMD_REF;
      w_bank = w_pick_ref[BA_W-1:0];
    end else if (w_pick_pre[BA_W]) begin
      w_cmd  = CMD_PRE;
      w_bank = w_pick_pre[BA_W-1:0];
    end else if (w_pick_col[BA_W]) begin
      w_bank = w_pick_col[BA_W-1:0];
      w_cmd  = rd_req_i[w_pick_col[BA_W-1:0]] ? CMD_RD : CMD_WR;
    end else if (w_pick_act[BA_W]) begin
      w_cmd  = CMD_ACT;
      w_bank = w_pick_act[BA_W-1:0];
    end
  end

  assign w_issue   = (w_cmd != CMD_NOP);
  assign w_bank_oh = {{(NUM_BANKS-1){1'b0}}, 1'b1} << w_bank;

  assign act_gnt_o = (rst_n && w_cmd == CMD_ACT) ? w_bank_oh : '0;
  assign rd_gnt_o  = (rst_n && w_cmd == CMD_RD)  ? w_bank_oh : '0;
  assign wr_gnt_o  = (rst_n && w_cmd == CMD_WR)  ? w_bank_oh : '0;
  assign pre_gnt_o = (rst_n && w_cmd == CMD_PRE) ? w_bank_oh : '0;
  assign ref_gnt_o = (rst_n && w_cmd == CMD_REF) ? w_bank_oh : '0;

  // Round-robin pointers advance past the granted bank of the winning class only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr_act <= '0;
      r_ptr_col <= '0;
      r_ptr_pre <= '0;
      r_ptr_ref <= '0;
    end else begin
      case (w_cmd)
        CMD_ACT:        r_ptr_act <= BA_W'((32'(w_bank) + 1) % NUM_BANKS);
        CMD_RD, CMD_WR: r_ptr_col <= BA_W'((32'(w_bank) + 1) % NUM_BANKS);
        CMD_PRE:        r_ptr_pre <= BA_W'((32'(w_bank) + 1) % NUM_BANKS);
        CMD_REF:        r_ptr_ref <= BA_W'((32'(w_bank) + 1) % NUM_BANKS);
        default: ;
      endcase
    end
  end

  // Saturating down-counters; loading T-1 makes the next command legal T cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrd_cnt   <= '0;
      r_ccd_cnt   <= '0;
      r_wr2rd_cnt <= '0;
      r_rd2wr_cnt <= '0;
    end else begin
      r_rrd_cnt   <= (w_cmd == CMD_ACT) ? CNT_W'(T_RRD - 1)
                   : (r_rrd_cnt != '0) ? r_rrd_cnt - 1'b1 : '0;
      r_ccd_cnt   <= (w_cmd == CMD_RD || w_cmd == CMD_WR) ? CNT_W'(T_CCD - 1)
                   : (r_ccd_cnt != '0) ? r_ccd_cnt - 1'b1 : '0;
      r_rd2wr_cnt <= (w_cmd == CMD_RD) ? CNT_W'(T_RD2WR - 1)
                   : (r_rd2wr_cnt != '0) ? r_rd2wr_cnt - 1'b1 : '0;
      r_wr2rd_cnt <= (w_cmd == CMD_WR) ? CNT_W'(T_WR2RD - 1)
                   : (r_wr2rd_cnt != '0) ? r_wr2rd_cnt - 1'b1 : '0;
    end
  end

  // Command register; address fields hold their last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd       <= CMD_NOP;
      r_ba        <= '0;
      r_pl        <= '0;
    end else begin
      r_cmd_valid <= w_issue;
      r_cmd       <= w_cmd;
      if (w_issue) begin
        r_ba     <= w_bank;
        r_pl.ra  <= ra_i[w_bank];
        r_pl.ca  <= ca_i[w_bank];
        r_pl.id  <= id_i[w_bank];
        r_pl.len <= len_i[w_bank];
      end
    end
  end

  assign cmd_valid_o = r_cmd_valid;
  assign cmd_o       = r_cmd;
  assign ba_o        = r_ba;
  assign ra_o        = r_pl.ra;
  assign ca_o        = r_pl.ca;
  assign id_o        = r_pl.id;
  assign len_o       = r_pl.len;

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Bench for sal_cmd_sched: directed scenarios plus random traffic against a
// timestamp-based reference model of the scheduling rules.

module tb_sal_cmd_sched;
  import sal_cmd_sched_pkg::*;

  localparam int NB = 4;
  localparam int T_RRD = 2, T_CCD = 2, T_WR2RD = 6, T_RD2WR = 4;

  logic clk, rst_n;
  logic [NB-1:0] act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i;
  dram_ra_t [NB-1:0] ra_i;
  dram_ca_t [NB-1:0] ca_i;
  axi_id_t  [NB-1:0] id_i;
  axi_len_t [NB-1:0] len_i;
  logic [NB-1:0] act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o;
  logic cmd_valid_o;
  logic [2:0] cmd_o;
  logic [1:0] ba_o;
  dram_ra_t ra_o;
  dram_ca_t ca_o;
  axi_id_t  id_o;
  axi_len_t len_o;

  sal_cmd_sched #(.NUM_BANKS(NB), .T_RRD(T_RRD), .T_CCD(T_CCD),
                  .T_WR2RD(T_WR2RD), .T_RD2WR(T_RD2WR)) dut (
    .clk(clk), .rst_n(rst_n),
    .act_req_i(act_req_i), .rd_req_i(rd_req_i), .wr_req_i(wr_req_i),
    .pre_req_i(pre_req_i), .ref_req_i(ref_req_i),
    .ra_i(ra_i), .ca_i(ca_i), .id_i(id_i), .len_i(len_i),
    .act_gnt_o(act_gnt_o), .rd_gnt_o(rd_gnt_o), .wr_gnt_o(wr_gnt_o),
    .pre_gnt_o(pre_gnt_o), .ref_gnt_o(ref_gnt_o),
    .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o), .ba_o(ba_o),
    .ra_o(ra_o), .ca_o(ca_o), .id_o(id_o), .len_o(len_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: issue timestamps instead of counters; pointers per class.
  int cyc;
  int last_act, last_col, last_rd, last_wr;
  int ptr_act, ptr_col, ptr_pre, ptr_ref;
  logic       m_valid;
  logic [2:0] m_cmd;
  logic [1:0] m_ba;
  dram_ra_t   m_ra;
  dram_ca_t   m_ca;
  axi_id_t    m_id;
  axi_len_t   m_len;

  task automatic model_reset();
    last_act = -1000; last_col = -1000; last_rd = -1000; last_wr = -1000;
    ptr_act = 0; ptr_col = 0; ptr_pre = 0; ptr_ref = 0;
    m_valid = 1'b0; m_cmd = 3'd0; m_ba = '0;
    m_ra = '0; m_ca = '0; m_id = '0; m_len = '0;
  endtask

  function automatic int rr(input logic [NB-1:0] v, input int ptr);
    for (int i = 0; i < NB; i++)
      if (v[(ptr + i) % NB]) return (ptr + i) % NB;
    return -1;
  endfunction

  // Drive one cycle of requests at a negedge, check grants, then the command a cycle later.
  task automatic step(input logic [NB-1:0] a, input logic [NB-1:0] r, input logic [NB-1:0] w,
                      input logic [NB-1:0] p, input logic [NB-1:0] f);
    logic [NB-1:0] col_ok, e_act, e_rd, e_wr, e_pre, e_ref;
    bit rrd_ok, rd_ok, wr_ok;
    int b, cls;
    act_req_i = a; rd_req_i = r; wr_req_i = w; pre_req_i = p; ref_req_i = f;
    for (int i = 0; i < NB; i++) begin
      ra_i[i] = dram_ra_t'($urandom); ca_i[i] = dram_ca_t'($urandom);
      id_i[i] = axi_id_t'($urandom);  len_i[i] = axi_len_t'($urandom);
    end
    #1;
    rrd_ok = (cyc - last_act) >= T_RRD;
    rd_ok  = ((cyc - last_col) >= T_CCD) && ((cyc - last_wr) >= T_WR2RD);
    wr_ok  = ((cyc - last_col) >= T_CCD) && ((cyc - last_rd) >= T_RD2WR);
    for (int i = 0; i < NB; i++)
      col_ok[i] = r[i] ? rd_ok : (w[i] && wr_ok);
    e_act = '0; e_rd = '0; e_wr = '0; e_pre = '0; e_ref = '0;
    cls = 0; b = -1;
    if (rr(f, ptr_ref) >= 0)                           begin cls = 5; b = rr(f, ptr_ref); end
    else if (rr(p, ptr_pre) >= 0)                      begin cls = 4; b = rr(p, ptr_pre); end
    else if (rr(col_ok, ptr_col) >= 0)                 begin b = rr(col_ok, ptr_col); cls = r[b] ? 2 : 3; end
    else if (rrd_ok && rr(a, ptr_act) >= 0)            begin cls = 1; b = rr(a, ptr_act); end
    case (cls)
      1: e_act[b] = 1'b1;
      2: e_rd[b]  = 1'b1;
      3: e_wr[b]  = 1'b1;
      4: e_pre[b] = 1'b1;
      5: e_ref[b] = 1'b1;
      default: ;
    endcase
    check_eq("act_gnt", act_gnt_o, e_act);
    check_eq("rd_gnt",  rd_gnt_o,  e_rd);
    check_eq("wr_gnt",  wr_gnt_o,  e_wr);
    check_eq("pre_gnt", pre_gnt_o, e_pre);
    check_eq("ref_gnt", ref_gnt_o, e_ref);
    m_valid = (cls != 0);
    m_cmd   = 3'(cls);
    if (cls != 0) begin
      m_ba = 2'(b); m_ra = ra_i[b]; m_ca = ca_i[b]; m_id = id_i[b]; m_len = len_i[b];
      case (cls)
        1: begin last_act = cyc; ptr_act = (b + 1) % NB; end
        2: begin last_col = cyc; last_rd = cyc; ptr_col = (b + 1) % NB; end
        3: begin last_col = cyc; last_wr = cyc; ptr_col = (b + 1) % NB; end
        4: ptr_pre = (b + 1) % NB;
        default: ptr_ref = (b + 1) % NB;
      endcase
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_eq("cmd_valid", cmd_valid_o, m_valid);
    check_eq("cmd", cmd_o, m_cmd);
    check_eq("ba", ba_o, m_ba);
    check_eq("ra", ra_o, m_ra);
    check_eq("ca", ca_o, m_ca);
    check_eq("id", id_o, m_id);
    check_eq("len", len_o, m_len);
  endtask

  task automatic idle_outputs_check(input string tag);
    check_eq({tag, "_valid"}, cmd_valid_o, 1'b0);
    check_eq({tag, "_cmd"}, cmd_o, 3'd0);
    check_eq({tag, "_gnts"}, {act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o}, 20'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    act_req_i = '0; rd_req_i = '0; wr_req_i = '0; pre_req_i = '0; ref_req_i = '0;
    ra_i = '0; ca_i = '0; id_i = '0; len_i = '0;
    cyc = 0;
    model_reset();

    // Reset then idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_outputs_check("rst");
      check_eq("rst_ba", ba_o, 2'd0);
    end
    act_req_i = 4'b1111; ref_req_i = 4'b1111; #1;
    check_eq("rst_gnt_masked", {act_gnt_o, ref_gnt_o}, 8'd0);
    act_req_i = '0; ref_req_i = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step('0, '0, '0, '0, '0);

    // tRRD with banks 0 and 1 requesting ACT
    for (int i = 0; i < 4; i++) step(4'b0011, '0, '0, '0, '0);

    // Class priority, then RD once REF drops
    step(4'b0010, 4'b0001, '0, '0, 4'b0100);
    check_eq("prio_cmd_ref", cmd_o, 3'd5);
    step('0, 4'b0001, '0, '0, '0);
    check_eq("prio_cmd_rd", {cmd_o, ba_o}, {3'd2, 2'd0});

    // Round-robin reads (pointer sits at 1 after the previous RD to bank 0)
    for (int i = 0; i < 10; i++) step('0, 4'b1111, '0, '0, '0);

    // WR-to-RD and RD-to-WR turnaround
    for (int i = 0; i < 6; i++) step('0, '0, '0, '0, '0);
    step('0, '0, 4'b0010, '0, '0);
    for (int i = 0; i < 7; i++) step('0, 4'b0100, '0, '0, '0);
    for (int i = 0; i < 5; i++) step('0, '0, 4'b0010, '0, '0);

    // Async reset right after an ACT (rrd counter non-zero)
    for (int i = 0; i < 3; i++) step('0, '0, '0, '0, '0);
    step(4'b0001, '0, '0, '0, '0);
    act_req_i = 4'b0010;
    #2 rst_n = 1'b0;
    #1;
    idle_outputs_check("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(4'b0010, '0, '0, '0, '0);
    check_eq("postrst_act", {cmd_valid_o, cmd_o, ba_o}, {1'b1, 3'd1, 2'd1});

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [NB-1:0] a, r, w, p, f;
      a = 4'($urandom); r = 4'($urandom) & 4'($urandom); w = 4'($urandom) & 4'($urandom);
      p = ($urandom_range(0, 5) == 0) ? 4'($urandom) : '0;
      f = ($urandom_range(0, 9) == 0) ? 4'($urandom) : '0;
      step(a, r, w, p, f);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
